// File: rtl/decode_stage_pkg.sv
// Shared decode types: immediate formats, RV32 major opcodes, control bundle and buffer states.
package decode_stage_pkg;

    typedef enum logic [2:0] {
        ENUM_IMM_NONE = 3'd0,
        ENUM_IMM_I    = 3'd1,
        ENUM_IMM_S    = 3'd2,
        ENUM_IMM_B    = 3'd3,
        ENUM_IMM_U    = 3'd4,
        ENUM_IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic [6:0] {
        OPC_LUI     = 7'b0110111,
        OPC_AUIPC   = 7'b0010111,
        OPC_JAL     = 7'b1101111,
        OPC_JALR    = 7'b1100111,
        OPC_BRANCH  = 7'b1100011,
        OPC_LOAD    = 7'b0000011,
        OPC_STORE   = 7'b0100011,
        OPC_OPIMM   = 7'b0010011,
        OPC_OP      = 7'b0110011,
        OPC_MISCMEM = 7'b0001111,
        OPC_SYSTEM  = 7'b1110011
    } opcode_e;

    typedef struct packed {
        imm_type_e immType;
        logic      regWrite;
        logic      memRead;
        logic      memWrite;
        logic      illegal;
    } dec_ctrl_t;

    localparam dec_ctrl_t CTRL_NONE = '{
        immType:  ENUM_IMM_NONE,
        regWrite: 1'b0,
        memRead:  1'b0,
        memWrite: 1'b0,
        illegal:  1'b0
    };

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// Combinational RV32 opcode decode: control bundle plus register/function fields.
module inst_decoder
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] inst,
    output dec_ctrl_t       ctrl,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic            funct7b5
);

    assign rd       = inst[11:7];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct3   = inst[14:12];
    assign funct7b5 = inst[30];

    always_comb begin
        ctrl = CTRL_NONE;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                ctrl.immType  = ENUM_IMM_U;
                ctrl.regWrite = 1'b1;
            end
            OPC_JAL: begin
                ctrl.immType  = ENUM_IMM_J;
                ctrl.regWrite = 1'b1;
            end
            OPC_JALR, OPC_OPIMM: begin
                ctrl.immType  = ENUM_IMM_I;
                ctrl.regWrite = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.immType  = ENUM_IMM_I;
                ctrl.regWrite = 1'b1;
                ctrl.memRead  = 1'b1;
            end
            OPC_SYSTEM:  ctrl.immType = ENUM_IMM_I;
            OPC_STORE: begin
                ctrl.immType  = ENUM_IMM_S;
                ctrl.memWrite = 1'b1;
            end
            OPC_BRANCH:  ctrl.immType = ENUM_IMM_B;
            OPC_OP:      ctrl.regWrite = 1'b1;
            OPC_MISCMEM: ctrl.regWrite = 1'b0;
            default:     ctrl.illegal = 1'b1;
        endcase
        // x0 is hardwired; never request a write to it
        if (inst[11:7] == 5'd0) begin
            ctrl.regWrite = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a 2-entry skid buffer (output reg + skid reg).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [PC_W-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [XLEN-1:0] o_inst,
    output imm_type_e       o_immType,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [2:0]      o_funct3,
    output logic            o_funct7b5,
    output logic            o_regWrite,
    output logic            o_memRead,
    output logic            o_memWrite,
    output logic            o_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] inst;
        dec_ctrl_t       ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
    } entry_t;

    entry_t     dec_entry;
    entry_t     out_q;
    entry_t     skid_q;
    buf_state_e state_q, state_d;
    logic       ready_q;
    logic       in_hs, out_hs;
    logic       load_out_new, load_out_skid, load_skid;

    assign dec_entry.pc   = i_pc;
    assign dec_entry.inst = i_inst;

    inst_decoder #(
        .XLEN(XLEN)
    ) u_inst_decoder (
        .inst    (i_inst),
        .ctrl    (dec_entry.ctrl),
        .rd      (dec_entry.rd),
        .rs1     (dec_entry.rs1),
        .rs2     (dec_entry.rs2),
        .funct3  (dec_entry.funct3),
        .funct7b5(dec_entry.funct7b5)
    );

    assign o_valid = (state_q != StEmpty);
    assign o_ready = ready_q;
    assign in_hs   = i_valid & ready_q;
    assign out_hs  = o_valid & i_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (in_hs) begin
                    state_d      = StBusy;
                    load_out_new = 1'b1;
                end
            end
            StBusy: begin
                if (in_hs && out_hs) begin
                    load_out_new = 1'b1;
                end else if (in_hs) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (out_hs) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_hs) begin
                    state_d       = StBusy;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (i_flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StEmpty;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFull);
        end
    end

    // Payload carries no reset; visibility is governed by state_q alone.
    always_ff @(posedge i_clk) begin
        if (load_out_new) begin
            out_q <= dec_entry;
        end else if (load_out_skid) begin
            out_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= dec_entry;
        end
    end

    always_comb begin
        o_pc       = '0;
        o_inst     = '0;
        o_immType  = ENUM_IMM_NONE;
        o_rd       = '0;
        o_rs1      = '0;
        o_rs2      = '0;
        o_funct3   = '0;
        o_funct7b5 = 1'b0;
        o_regWrite = 1'b0;
        o_memRead  = 1'b0;
        o_memWrite = 1'b0;
        o_illegal  = 1'b0;
        if (o_valid) begin
            o_pc       = out_q.pc;
            o_inst     = out_q.inst;
            o_immType  = out_q.ctrl.immType;
            o_rd       = out_q.rd;
            o_rs1      = out_q.rs1;
            o_rs2      = out_q.rs2;
            o_funct3   = out_q.funct3;
            o_funct7b5 = out_q.funct7b5;
            o_regWrite = out_q.ctrl.regWrite;
            o_memRead  = out_q.ctrl.memRead;
            o_memWrite = out_q.ctrl.memWrite;
            o_illegal  = out_q.ctrl.illegal;
        end
    end

endmodule
